reg_write_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write path into the CPU's bank of 18-bit registers among N_REQ requesters. Sources include ALU result, memory load, PC update and the control unit.
- Each requester asks to write data to, or clear, one destination register.
- One grant per cycle. The winner's request is turned into registered per-register enable, clear and data drives for the register bank.

---
 rtl/cpu_reg_pkg.sv | 12 +
 rtl/rr_priority_picker.sv | 30 +++
 rtl/reg_write_arbiter.sv | 110 +++++++++++
 tb/tb_reg_write_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_reg_pkg.sv
// Shared constants and types for the CPU register bank and its write path.
package cpu_reg_pkg;

    localparam int DATA_W = 18;
    localparam int N_REQ  = 4;
    localparam int N_REG  = 4;
    localparam int REG_AW = 2;

    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [REG_AW-1:0] reg_idx_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin selector: first asserted request at or above ptr_i, wrapping.
module rr_priority_picker #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0] win_idx_o,
    output logic             win_vld_o
);

    int idx;

    always_comb begin
        gnt_o     = '0;
        win_idx_o = '0;
        win_vld_o = 1'b0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_i) + k) % N_REQ;
            if (!win_vld_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                win_idx_o  = PTR_W'(idx);
                win_vld_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the single register-bank write path; the winner's request
// becomes registered one-hot enable/clear plus data for the bank in the following cycle.
module reg_write_arbiter
    import cpu_reg_pkg::*;
#(
    parameter int DATA_W = cpu_reg_pkg::DATA_W,
    parameter int N_REQ  = cpu_reg_pkg::N_REQ,
    parameter int N_REG  = cpu_reg_pkg::N_REG,
    parameter int REG_AW = cpu_reg_pkg::REG_AW
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_clr,
    input  logic [N_REQ*REG_AW-1:0]  req_dest,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         gnt,
    output logic [DATA_W-1:0]        reg_in,
    output logic [N_REG-1:0]         reg_enable,
    output logic [N_REG-1:0]         reg_clear,
    output logic                     busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  win_idx;
    logic              win_vld;
    logic [N_REQ-1:0]  pick_gnt;

    logic              win_clr;
    logic [REG_AW-1:0] win_dest;
    logic [DATA_W-1:0] win_data;
    logic [N_REG-1:0]  dest_onehot;

    logic [N_REG-1:0]  enable_q, enable_d;
    logic [N_REG-1:0]  clear_q, clear_d;
    logic [DATA_W-1:0] data_q, data_d;

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .gnt_o     (pick_gnt),
        .win_idx_o (win_idx),
        .win_vld_o (win_vld)
    );

    // A grant seen during reset would be dropped at the edge, so hide it.
    assign gnt  = RST_N ? pick_gnt : '0;
    assign busy = |req;

    always_comb begin
        win_clr  = 1'b0;
        win_dest = '0;
        win_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_idx == PTR_W'(k)) begin
                win_clr  = req_clr[k];
                win_dest = req_dest[k*REG_AW +: REG_AW];
                win_data = req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Out-of-range destinations decode to no bit at all.
    always_comb begin
        dest_onehot = '0;
        for (int r = 0; r < N_REG; r++) begin
            dest_onehot[r] = (int'(win_dest) == r);
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        enable_d = '0;
        clear_d  = '0;
        data_d   = '0;
        if (win_vld) begin
            ptr_d = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + PTR_W'(1);
            if (win_clr) begin
                clear_d = dest_onehot;
            end else begin
                enable_d = dest_onehot;
                data_d   = win_data;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q    <= '0;
            enable_q <= '0;
            clear_q  <= '0;
            data_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            enable_q <= enable_d;
            clear_q  <= clear_d;
            data_q   <= data_d;
        end
    end

    assign reg_enable = enable_q;
    assign reg_clear  = clear_q;
    assign reg_in     = data_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized bench for reg_write_arbiter against a round-robin reference model.
module tb_reg_write_arbiter;

    localparam int NR = 4;
    localparam int NG = 4;
    localparam int DW = 18;
    localparam int AW = 2;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic [NR-1:0]    req = '0;
    logic [NR-1:0]    req_clr = '0;
    logic [NR*AW-1:0] req_dest = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]    gnt;
    logic [DW-1:0]    reg_in;
    logic [NG-1:0]    reg_enable;
    logic [NG-1:0]    reg_clear;
    logic             busy;

    reg_write_arbiter dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .req        (req),
        .req_clr    (req_clr),
        .req_dest   (req_dest),
        .req_data   (req_data),
        .gnt        (gnt),
        .reg_in     (reg_in),
        .reg_enable (reg_enable),
        .reg_clear  (reg_clear),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // requester intentions
    bit            p_req  [NR];
    bit            p_clr  [NR];
    int            p_dest [NR];
    logic [DW-1:0] p_data [NR];

    // reference state
    int            m_ptr;
    logic [NG-1:0] m_en, m_clr;
    logic [DW-1:0] m_in;
    logic [NR-1:0] last_gnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_pick();
        for (int k = 0; k < NR; k++) begin
            if (p_req[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr    = 0;
        m_en     = '0;
        m_clr    = '0;
        m_in     = '0;
        last_gnt = '0;
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req[i]               = p_req[i];
            req_clr[i]           = p_clr[i];
            req_dest[i*AW +: AW] = AW'(p_dest[i]);
            req_data[i*DW +: DW] = p_data[i];
        end
    endtask

    // One arbitration cycle: drive, check mid-cycle, advance the model at the edge.
    task automatic step();
        int w;
        logic [NR-1:0] exp_gnt;
        drive();
        w = model_pick();
        exp_gnt = (w < 0) ? '0 : NR'(1 << w);
        @(negedge CLK);
        check_eq("gnt", 32'(gnt), 32'(exp_gnt));
        check_eq("busy", 32'(busy), 32'(|req));
        check_eq("reg_enable", 32'(reg_enable), 32'(m_en));
        check_eq("reg_clear", 32'(reg_clear), 32'(m_clr));
        check_eq("reg_in", 32'(reg_in), 32'(m_in));
        check_eq("no_repeat", 32'(gnt != 0 && gnt == last_gnt && (req & ~gnt) != 0), 32'(0));
        last_gnt = gnt;
        @(posedge CLK);
        if (w >= 0) begin
            m_ptr = (w + 1) % NR;
            if (p_clr[w]) begin
                m_clr = (p_dest[w] < NG) ? NG'(1 << p_dest[w]) : '0;
                m_en  = '0;
                m_in  = '0;
            end else begin
                m_en  = (p_dest[w] < NG) ? NG'(1 << p_dest[w]) : '0;
                m_clr = '0;
                m_in  = p_data[w];
            end
            p_req[w] = 1'b0;
        end else begin
            m_en  = '0;
            m_clr = '0;
            m_in  = '0;
        end
        #1;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NR; i++) begin
            p_req[i]  = 1'b0;
            p_clr[i]  = 1'b0;
            p_dest[i] = 0;
            p_data[i] = '0;
        end
    endtask

    task automatic apply_reset();
        clear_reqs();
        drive();
        RST_N = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        model_reset();
    endtask

    task automatic set_req(input int i, input bit clr, input int dest, input logic [DW-1:0] data);
        p_req[i]  = 1'b1;
        p_clr[i]  = clr;
        p_dest[i] = dest;
        p_data[i] = data;
    endtask

    initial begin
        model_reset();
        clear_reqs();
        drive();
        #12;
        check_eq("rst_gnt", 32'(gnt), 32'(0));
        check_eq("rst_enable", 32'(reg_enable), 32'(0));
        check_eq("rst_in", 32'(reg_in), 32'(0));
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // single write to reg 2
        set_req(0, 1'b0, 2, 18'h2AAAA);
        step();
        step();
        check_eq("t1_enable", 32'(reg_enable), 32'(4'b0000));

        // all four held: rotation from ptr 0
        apply_reset();
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < NR; i++) set_req(i, 1'b0, (i + n) % NG, DW'(18'h01000 * (i + 1) + n));
            step();
        end
        clear_reqs();
        step();

        // clear of reg 3 ignores data
        apply_reset();
        set_req(1, 1'b1, 3, 18'h3F0F3);
        step();
        step();

        // req0 and req2 contending from ptr 1
        apply_reset();
        set_req(0, 1'b0, 0, 18'h00011);
        step();
        for (int n = 0; n < 5; n++) begin
            set_req(0, 1'b0, 0, DW'(18'h10000 + n));
            set_req(2, 1'b0, 1, DW'(18'h20000 + n));
            step();
        end
        clear_reqs();

        // idle cycles
        for (int n = 0; n < 5; n++) step();

        // reset mid-operation
        set_req(1, 1'b0, 1, 18'h15555);
        step();
        p_req[3] = 1'b1; p_clr[3] = 1'b0; p_dest[3] = 0; p_data[3] = 18'h0ABCD;
        drive();
        #2;
        check_eq("t5_pre_enable", 32'(reg_enable), 32'(4'b0010));
        RST_N = 1'b0;
        #1;
        check_eq("t5_rst_enable", 32'(reg_enable), 32'(0));
        check_eq("t5_rst_clear", 32'(reg_clear), 32'(0));
        check_eq("t5_rst_in", 32'(reg_in), 32'(0));
        check_eq("t5_rst_gnt", 32'(gnt), 32'(0));
        @(posedge CLK);
        #1;
        check_eq("t5_hold_gnt", 32'(gnt), 32'(0));
        RST_N = 1'b1;
        model_reset();
        step();
        step();

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!p_req[i] && ($urandom_range(0, 99) < 55)) begin
                    set_req(i, ($urandom_range(0, 3) == 0), int'($urandom_range(0, NG - 1)),
                            DW'($urandom()));
                end
            end
            step();
        end
        clear_reqs();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
